// File: rtl/half_adder.sv
// Single-bit half adder; one stage of the incrementer's ripple chain.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/increment.sv
// Unsigned +1 incrementer: combinational result for counter next-state logic,
// plus an optional registered copy for pipelined users.
module increment #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic [WIDTH-1:0] out_q,
  output logic             cout_q
);

  // Carry chain is WIDTH+1 bits; the forced carry-in supplies the +1.
  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    half_adder u_ha (
      .a(in[i]),
      .b(c[i]),
      .s(out[i]),
      .c(c[i+1])
    );
  end

  assign cout = c[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      cout_q <= 1'b0;
    end else if (en) begin
      out_q  <= out;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_increment.sv
// Directed bench for increment: vector tables for the combinational path
// plus hand sequences for the register, reset priority and counter loop.
module tb_increment;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=3 instance: sweep, register path and reset priority.
  logic       r3, e3, c3, cq3;
  logic [2:0] i3, o3, oq3;
  increment #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(r3), .en(e3), .in(i3),
    .out(o3), .cout(c3), .out_q(oq3), .cout_q(cq3)
  );

  // WIDTH=1 corner instance.
  logic       r1, e1, c1, cq1;
  logic [0:0] i1, o1, oq1;
  increment #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(r1), .en(e1), .in(i1),
    .out(o1), .cout(c1), .out_q(oq1), .cout_q(cq1)
  );

  // WIDTH=8 corner instance.
  logic       r8, e8, c8, cq8;
  logic [7:0] i8, o8, oq8;
  increment #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(r8), .en(e8), .in(i8),
    .out(o8), .cout(c8), .out_q(oq8), .cout_q(cq8)
  );

  // Closed-loop counter: next state comes straight from the incrementer.
  logic       cnt_reset, cnt_cout, cnt_cq;
  logic [2:0] ps, cnt_out, cnt_oq;
  increment #(.WIDTH(3)) dutc (
    .clk(clk), .reset(cnt_reset), .en(1'b0), .in(ps),
    .out(cnt_out), .cout(cnt_cout), .out_q(cnt_oq), .cout_q(cnt_cq)
  );
  always_ff @(posedge clk) ps <= cnt_reset ? 3'd0 : cnt_out;

  typedef struct {
    int         w;
    logic [7:0] vin;
    logic [7:0] exp_out;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r3 = 1'b1; e3 = 1'b0; i3 = '0;
    r1 = 1'b1; e1 = 1'b0; i1 = '0;
    r8 = 1'b1; e8 = 1'b0; i8 = '0;
    cnt_reset = 1'b1;

    // Hand-computed vectors.
    vecs.push_back('{3, 8'd0, 8'd1, 1'b0});
    vecs.push_back('{3, 8'd1, 8'd2, 1'b0});
    vecs.push_back('{3, 8'd2, 8'd3, 1'b0});
    vecs.push_back('{3, 8'd3, 8'd4, 1'b0});
    vecs.push_back('{3, 8'd4, 8'd5, 1'b0});
    vecs.push_back('{3, 8'd5, 8'd6, 1'b0});
    vecs.push_back('{3, 8'd6, 8'd7, 1'b0});
    vecs.push_back('{3, 8'd7, 8'd0, 1'b1});
    vecs.push_back('{1, 8'd0, 8'd1, 1'b0});
    vecs.push_back('{1, 8'd1, 8'd0, 1'b1});
    vecs.push_back('{8, 8'hFF, 8'h00, 1'b1});
    vecs.push_back('{8, 8'h7F, 8'h80, 1'b0});
    vecs.push_back('{8, 8'h00, 8'h01, 1'b0});
    vecs.push_back('{8, 8'hA5, 8'hA6, 1'b0});

    tick();
    check("rst_out_q3",  {29'd0, oq3}, 32'd0);
    check("rst_cout_q3", {31'd0, cq3}, 32'd0);
    check("rst_out_q8",  {24'd0, oq8}, 32'd0);
    check("rst_out_q1",  {31'd0, oq1}, 32'd0);

    // Combinational table, applied while reset is still asserted.
    foreach (vecs[k]) begin
      case (vecs[k].w)
        1: i1 = vecs[k].vin[0:0];
        3: i3 = vecs[k].vin[2:0];
        default: i8 = vecs[k].vin;
      endcase
      #1;
      case (vecs[k].w)
        1: begin
          check($sformatf("w1_out_%0h", vecs[k].vin),  {31'd0, o1}, {31'd0, vecs[k].exp_out[0]});
          check($sformatf("w1_cout_%0h", vecs[k].vin), {31'd0, c1}, {31'd0, vecs[k].exp_cout});
        end
        3: begin
          check($sformatf("w3_out_%0h", vecs[k].vin),  {29'd0, o3}, {29'd0, vecs[k].exp_out[2:0]});
          check($sformatf("w3_cout_%0h", vecs[k].vin), {31'd0, c3}, {31'd0, vecs[k].exp_cout});
        end
        default: begin
          check($sformatf("w8_out_%0h", vecs[k].vin),  {24'd0, o8}, {24'd0, vecs[k].exp_out});
          check($sformatf("w8_cout_%0h", vecs[k].vin), {31'd0, c8}, {31'd0, vecs[k].exp_cout});
        end
      endcase
    end

    // Register path on WIDTH=3.
    r3 = 1'b0; e3 = 1'b1; i3 = 3'd5;
    tick();
    check("reg_load_6",   {29'd0, oq3}, 32'd6);
    check("reg_load_c0",  {31'd0, cq3}, 32'd0);
    e3 = 1'b0; i3 = 3'd2;
    tick();
    check("reg_hold_6",   {29'd0, oq3}, 32'd6);
    tick();
    check("reg_hold_6b",  {29'd0, oq3}, 32'd6);
    e3 = 1'b1; i3 = 3'd7;
    tick();
    check("reg_wrap_0",   {29'd0, oq3}, 32'd0);
    check("reg_wrap_c1",  {31'd0, cq3}, 32'd1);
    e3 = 1'b1; i3 = 3'd3;
    tick();
    check("reg_load_4",   {29'd0, oq3}, 32'd4);

    // Reset beats enable; combinational path still live during reset.
    r3 = 1'b1; e3 = 1'b1; i3 = 3'd7;
    #1;
    check("prio_comb_out",  {29'd0, o3}, 32'd0);
    check("prio_comb_cout", {31'd0, c3}, 32'd1);
    tick();
    check("prio_out_q",  {29'd0, oq3}, 32'd0);
    check("prio_cout_q", {31'd0, cq3}, 32'd0);
    r3 = 1'b0;

    // WIDTH=1 and WIDTH=8 registered loads.
    r1 = 1'b0; e1 = 1'b1; i1 = 1'b1;
    r8 = 1'b0; e8 = 1'b1; i8 = 8'hFF;
    tick();
    check("w1_reg_out",  {31'd0, oq1}, 32'd0);
    check("w1_reg_cout", {31'd0, cq1}, 32'd1);
    check("w8_reg_out",  {24'd0, oq8}, 32'd0);
    check("w8_reg_cout", {31'd0, cq8}, 32'd1);

    // Closed-loop counter: 0..7,0,1,2 with carry on the 7->0 step.
    cnt_reset = 1'b1;
    tick();
    cnt_reset = 1'b0;
    for (int unsigned k = 0; k < 11; k++) begin
      check($sformatf("cnt_ps_%0d", k),   {29'd0, ps}, k % 8);
      check($sformatf("cnt_cout_%0d", k), {31'd0, cnt_cout}, (k % 8 == 7) ? 32'd1 : 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
